hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/otter_pipe_pkg.sv | 29 ++
 rtl/fwd_sel.sv | 35 +++
 rtl/hazard_ctrl_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pipe_pkg.sv
// ---------------------------------------------------------------------------
// otter_pipe_pkg
// Shared pipeline types for the OTTER hazard control slice.
//   hazard_state_t : hazard FSM states (S_INIT, S_RUN, S_MEMWAIT)
//   fwd_sel_t      : ALU operand source select and its encodings
//                    FWD_REG (regfile), FWD_MEM (M stage), FWD_WB (W stage)
//   reg_match()    : true when a producing destination register is a real
//                    register (not x0) and equals a consumer source index
// ---------------------------------------------------------------------------
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        S_INIT    = 2'b00,
        S_RUN     = 2'b01,
        S_MEMWAIT = 2'b10
    } hazard_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Operand forwarding select for one ALU source in the E stage.
// The M-stage result is newer than the W-stage result, so it wins.
// Ports:
//   rs_E        in  5  source register index in E
//   rd_M, rd_W  in  5  destination indices of the M and W stages
//   regWrite_M  in  1  M stage will write rd_M
//   regWrite_W  in  1  W stage will write rd_W
//   sel         out 2  FWD_MEM / FWD_WB / FWD_REG
// ---------------------------------------------------------------------------
module fwd_sel
    import otter_pipe_pkg::*;
(
    input  logic [4:0] rs_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regWrite_M,
    input  logic       regWrite_W,
    output logic [1:0] sel
);

    // Pick the youngest in-flight producer of rs_E, else the register file.
    always_comb begin
        sel = FWD_REG;
        if (regWrite_M && reg_match(rd_M, rs_E)) begin
            sel = FWD_MEM;
        end else if (regWrite_W && reg_match(rd_W, rs_E)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
// Stall / flush / forwarding control for a 5-stage pipeline.
//   - Data-memory miss: freezes F/D/E/M until dmem_ready, with a saturating
//     wait counter and a sticky dmem_timeout flag.
//   - Taken branch: flushes D and E.
//   - Load-use: stalls F/D for one cycle and bubbles E.
//   - Operand forwarding for both ALU sources (two fwd_sel instances).
// Priority: memory miss > branch > load-use. A branch that arrives while
// the pipe is frozen is remembered and serviced in the first running cycle.
// Ports:
//   CLK, RST (sync, active-high)
//   rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W  register indices
//   regWrite_M, regWrite_W, memRead_E, mem_req_M, branch_taken_E, dmem_ready
//   stall_F/D/E/M, flush_D/E   pipeline register controls
//   fwdA_E, fwdB_E             ALU operand selects
//   dmem_timeout               sticky wait-limit flag
// Configuration macro HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import otter_pipe_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regWrite_M,
    input  logic       regWrite_W,
    input  logic       memRead_E,
    input  logic       mem_req_M,
    input  logic       branch_taken_E,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       dmem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Counter width is a parameter in both builds; it is folded in here so
    // instantiation is identical whether or not the counters are present.
    localparam int WCNT_W = $clog2(WAIT_MAX + 2) + (CNT_W * 0);
    localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

    hazard_state_t     state_r;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic              timeout_r;
    logic              br_pend_r;

    logic       miss_s;
    logic       branch_eff_s;
    logic       load_use_s;
    logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    fwd_sel u_fwd_a (
        .rs_E       (rs1_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regWrite_M (regWrite_M),
        .regWrite_W (regWrite_W),
        .sel        (fwd_a_s)
    );

    fwd_sel u_fwd_b (
        .rs_E       (rs2_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regWrite_M (regWrite_M),
        .regWrite_W (regWrite_W),
        .sel        (fwd_b_s)
    );

    // Hazard conditions; a remembered branch counts as a live branch.
    always_comb begin
        miss_s       = mem_req_M && !dmem_ready;
        branch_eff_s = branch_taken_E || br_pend_r;
        load_use_s   = memRead_E && (reg_match(rd_E, rs1_D) || reg_match(rd_E, rs2_D));
    end

    // Stall/flush decode. Stall and flush never hit the same stage together.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        if (RST) begin
            stall_f_s = 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                end
                S_RUN: begin
                    if (miss_s) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        stall_e_s = 1'b1;
                        stall_m_s = 1'b1;
                    end else if (branch_eff_s) begin
                        flush_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else if (load_use_s) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else begin
                        stall_f_s = 1'b0;
                    end
                end
                S_MEMWAIT: begin
                    // Release the freeze in the same cycle the data arrives.
                    if (!dmem_ready) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        stall_e_s = 1'b1;
                        stall_m_s = 1'b1;
                    end else begin
                        stall_f_s = 1'b0;
                    end
                end
                default: begin
                    stall_f_s = 1'b0;
                end
            endcase
        end
    end

    // Hazard FSM with wait counter, sticky timeout and pending-branch memory.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_INIT;
            wait_cnt_r <= {WCNT_W{1'b0}};
            timeout_r  <= 1'b0;
            br_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    state_r <= S_RUN;
                end
                S_RUN: begin
                    if (miss_s) begin
                        state_r    <= S_MEMWAIT;
                        wait_cnt_r <= {WCNT_W{1'b0}};
                        if (branch_taken_E) begin
                            br_pend_r <= 1'b1;
                        end
                    end else if (branch_eff_s) begin
                        br_pend_r <= 1'b0;
                    end
                end
                S_MEMWAIT: begin
                    if (dmem_ready) begin
                        state_r <= S_RUN;
                    end
                    if (wait_cnt_r != WAIT_SAT) begin
                        wait_cnt_r <= wait_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
                    end
                    // Incremented count goes past the limit.
                    if (wait_cnt_r >= WAIT_LIM) begin
                        timeout_r <= 1'b1;
                    end
                    if (branch_taken_E) begin
                        br_pend_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

    // Output drive; forwarding is forced to the register file during reset.
    always_comb begin
        stall_F      = stall_f_s;
        stall_D      = stall_d_s;
        stall_E      = stall_e_s;
        stall_M      = stall_m_s;
        flush_D      = flush_d_s;
        flush_E      = flush_e_s;
        dmem_timeout = timeout_r;
        if (RST) begin
            fwdA_E = FWD_REG;
            fwdB_E = FWD_REG;
        end else begin
            fwdA_E = fwd_a_s;
            fwdB_E = fwd_b_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Performance counters, wrapping; the start-up flush is not counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_f_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_d_s && (state_r != S_INIT)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios followed by
// random traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl_unit;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       regWrite_M, regWrite_W, memRead_E, mem_req_M, branch_taken_E, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, dmem_timeout;
    logic [1:0] fwdA_E, fwdB_E;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl_unit #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .regWrite_M(regWrite_M), .regWrite_W(regWrite_W), .memRead_E(memRead_E),
        .mem_req_M(mem_req_M), .branch_taken_E(branch_taken_E), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .dmem_timeout(dmem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, in terms of the behaviour rather than an encoding.
    bit     m_starting;   // first cycle after reset release
    bit     m_frozen;     // a data-memory miss is outstanding
    int     m_waited;     // cycles spent waiting since the miss began
    bit     m_timeout;
    bit     m_branch_owed;
    longint m_stalls, m_flushes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (regWrite_M && rd_M != 5'd0 && rd_M == rs) return 2'b10;
        if (regWrite_W && rd_W != 5'd0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Check the current cycle at the falling edge, then advance the model.
    task automatic cyc();
        logic sf, sd, se, sm, fd, fe;
        logic [1:0] fa, fb;
        @(negedge CLK);
        {sf, sd, se, sm, fd, fe} = 6'b0;
        fa = RST ? 2'b00 : fwd_ref(rs1_E);
        fb = RST ? 2'b00 : fwd_ref(rs2_E);
        if (RST) begin
            fd = 1'b0;
        end else if (m_starting) begin
            fd = 1'b1; fe = 1'b1;
        end else if (m_frozen) begin
            if (!dmem_ready) {sf, sd, se, sm} = 4'hF;
        end else if (mem_req_M && !dmem_ready) begin
            {sf, sd, se, sm} = 4'hF;
        end else if (branch_taken_E || m_branch_owed) begin
            fd = 1'b1; fe = 1'b1;
        end else if (memRead_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D)) begin
            sf = 1'b1; sd = 1'b1; fe = 1'b1;
        end
        chk("stall_F", stall_F, sf);
        chk("stall_D", stall_D, sd);
        chk("stall_E", stall_E, se);
        chk("stall_M", stall_M, sm);
        chk("flush_D", flush_D, fd);
        chk("flush_E", flush_E, fe);
        chk("fwdA_E", fwdA_E, fa);
        chk("fwdB_E", fwdB_E, fb);
        chk("dmem_timeout", dmem_timeout, m_timeout);
        chk("no_stall_flush_D", stall_D & flush_D, 1'b0);
        chk("no_stall_flush_E", stall_E & flush_E, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stalls[31:0]);
        chk("flush_cnt", flush_cnt, m_flushes[31:0]);
`endif
        if (RST) begin
            m_starting = 1'b1; m_frozen = 1'b0; m_waited = 0; m_timeout = 1'b0;
            m_branch_owed = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls += longint'(sf);
            if (fd && !m_starting) m_flushes++;
            if (m_starting) begin
                m_starting = 1'b0;
            end else if (m_frozen) begin
                if (m_waited <= WAIT_MAX) m_waited++;
                if (m_waited > WAIT_MAX) m_timeout = 1'b1;
                if (branch_taken_E) m_branch_owed = 1'b1;
                if (dmem_ready) m_frozen = 1'b0;
            end else if (mem_req_M && !dmem_ready) begin
                m_frozen = 1'b1; m_waited = 0;
                if (branch_taken_E) m_branch_owed = 1'b1;
            end else if (branch_taken_E || m_branch_owed) begin
                m_branch_owed = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {regWrite_M, regWrite_W, memRead_E, mem_req_M, branch_taken_E} = '0;
        dmem_ready = 1'b1;
    endtask

    initial begin
        RST = 1'b1;
        quiet();
        m_starting = 1'b1; m_frozen = 1'b0; m_waited = 0; m_timeout = 1'b0;
        m_branch_owed = 1'b0; m_stalls = 0; m_flushes = 0;

        // Reset held, then released: one start-up flush cycle, then idle.
        repeat (3) cyc();
        RST = 1'b0;
        #2 chk("init_flush_D", flush_D, 1'b1);
        cyc();
        #2 chk("run_idle_flush_D", flush_D, 1'b0);
        repeat (2) cyc();

        // Load-use on rs2, then the same with x0 as destination.
        memRead_E = 1'b1; rd_E = 5'd5; rs2_D = 5'd5;
        #2 chk("loaduse_stall_D", stall_D, 1'b1);
        cyc();
        quiet();
        cyc();
        memRead_E = 1'b1; rd_E = 5'd0; rs2_D = 5'd0;
        #2 chk("loaduse_x0_stall_F", stall_F, 1'b0);
        cyc();
        quiet();

        // Three-cycle miss, released when data arrives.
        mem_req_M = 1'b1; dmem_ready = 1'b0;
        repeat (3) cyc();
        dmem_ready = 1'b1;
        #2 chk("miss_release_stall_M", stall_M, 1'b0);
        cyc();
        quiet();
        cyc();

        // Branch together with load-use: branch wins.
        branch_taken_E = 1'b1; memRead_E = 1'b1; rd_E = 5'd5; rs2_D = 5'd5;
        #2 chk("br_loaduse_stall_D", stall_D, 1'b0);
        cyc();
        quiet();

        // Forwarding priority M over W.
        rd_M = 5'd7; rd_W = 5'd7; regWrite_M = 1'b1; regWrite_W = 1'b1; rs1_E = 5'd7;
        #2 chk("fwdA_mem", fwdA_E, 2'b10);
        cyc();
        regWrite_M = 1'b0;
        #2 chk("fwdA_wb", fwdA_E, 2'b01);
        cyc();
        quiet();

        // Branch arriving during a miss is serviced after the miss.
        mem_req_M = 1'b1; dmem_ready = 1'b0; branch_taken_E = 1'b1;
        repeat (2) cyc();
        dmem_ready = 1'b1; branch_taken_E = 1'b0; mem_req_M = 1'b0;
        cyc();
        #2 chk("owed_branch_flush_E", flush_E, 1'b1);
        cyc();
        cyc();

        // Long miss: timeout is sticky until reset.
        mem_req_M = 1'b1; dmem_ready = 1'b0;
        repeat (20) cyc();
        quiet();
        repeat (3) cyc();
        #2 chk("timeout_sticky", dmem_timeout, 1'b1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        cyc();

        // Reset in the middle of a miss leaves no residual stall.
        mem_req_M = 1'b1; dmem_ready = 1'b0;
        repeat (3) cyc();
        RST = 1'b1; quiet();
        cyc();
        RST = 1'b0;
        repeat (2) cyc();
        #2 chk("post_reset_stall_F", stall_F, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            RST            = ($urandom_range(0, 79) == 0);
            rs1_D          = 5'($urandom_range(0, 3));
            rs2_D          = 5'($urandom_range(0, 3));
            rs1_E          = 5'($urandom_range(0, 3));
            rs2_E          = 5'($urandom_range(0, 3));
            rd_E           = 5'($urandom_range(0, 3));
            rd_M           = 5'($urandom_range(0, 3));
            rd_W           = 5'($urandom_range(0, 3));
            regWrite_M     = 1'($urandom_range(0, 1));
            regWrite_W     = 1'($urandom_range(0, 1));
            memRead_E      = 1'($urandom_range(0, 1));
            mem_req_M      = ($urandom_range(0, 3) == 0);
            branch_taken_E = ($urandom_range(0, 4) == 0);
            dmem_ready     = ($urandom_range(0, 9) < 3);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
